apb_interconnect: RTL and testbench

APB_INTERCONNECT -- requirements
Module: apb_interconnect

---
 rtl/apb_interconnect_if.sv | 53 +++++
 rtl/apb_interconnect.sv | 162 ++++++++++++++++
 tb/tb_apb_interconnect.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_interconnect_if.sv
// ----------------------------------------------------------------------------
// apb_interconnect_if
// Bundles the initiator-side APB port and the shared target-side APB bus of
// apb_interconnect.
//   slave  : view used by apb_interconnect. It receives the initiator request
//            and the target responses, and drives the initiator response and
//            the target request.
//   master : opposite view, used by the initiator/target models around it.
// Signals
//   i_psel, i_penable, i_paddr, i_pwrite, i_pwdata, i_pwstrb : initiator request
//   i_pready, i_prdata, i_pslverr                            : initiator response
//   t_psel (one-hot), t_penable, t_pwrite, t_paddr,
//   t_pwdata, t_pwstrb                                       : target request
//   t_pready, t_pslverr, t_prdata (N_TGT x 32)               : target responses
// ----------------------------------------------------------------------------
interface apb_interconnect_if #(
   parameter int N_TGT      = 2,
   parameter int TGT_ADDR_W = 31
);
   logic                    i_psel;
   logic                    i_penable;
   logic [31:0]             i_paddr;
   logic                    i_pwrite;
   logic [31:0]             i_pwdata;
   logic [3:0]              i_pwstrb;
   logic                    i_pready;
   logic [31:0]             i_prdata;
   logic                    i_pslverr;

   logic [N_TGT-1:0]        t_psel;
   logic                    t_penable;
   logic                    t_pwrite;
   logic [TGT_ADDR_W-1:0]   t_paddr;
   logic [31:0]             t_pwdata;
   logic [3:0]              t_pwstrb;
   logic [N_TGT-1:0]        t_pready;
   logic [N_TGT-1:0]        t_pslverr;
   logic [N_TGT*32-1:0]     t_prdata;

   modport slave (
      input  i_psel, i_penable, i_paddr, i_pwrite, i_pwdata, i_pwstrb,
      input  t_pready, t_pslverr, t_prdata,
      output i_pready, i_prdata, i_pslverr,
      output t_psel, t_penable, t_pwrite, t_paddr, t_pwdata, t_pwstrb
   );

   modport master (
      output i_psel, i_penable, i_paddr, i_pwrite, i_pwdata, i_pwstrb,
      output t_pready, t_pslverr, t_prdata,
      input  i_pready, i_prdata, i_pslverr,
      input  t_psel, t_penable, t_pwrite, t_paddr, t_pwdata, t_pwstrb
   );
endinterface

// File: rtl/apb_interconnect.sv
// ----------------------------------------------------------------------------
// apb_interconnect
// Single-initiator to N_TGT-target APB decoder. One transfer at a time moves
// through IDLE -> SETUP -> ACCESS -> RESP (address hit) or IDLE -> ERR (miss).
// The request is captured in IDLE, so the initiator may drop its signals once
// the setup phase has been sampled; the target transfer still completes.
// Ports
//   clk   : clock, all state on the rising edge
//   rst_n : synchronous active-low reset (state to IDLE, all outputs 0)
//   bus   : apb_interconnect_if.slave (initiator request/response, shared
//           target request, per-target responses)
// Optional feature
//   APB_INTERCONNECT_TIMEOUT_EN : when defined, an ACCESS phase lasting
//   TIMEOUT_CYC cycles without t_pready ends in ERR. When undefined, ACCESS
//   waits for the target indefinitely and no counter exists.
// ----------------------------------------------------------------------------
module apb_interconnect #(
   parameter int                  N_TGT       = 2,
   parameter int                  TGT_ADDR_W  = 31,
   parameter logic [N_TGT*32-1:0] BASE_ADDR   = {32'h1000_0000, 32'h8000_0000},
   parameter logic [N_TGT*32-1:0] ADDR_MASK   = {32'hFFFF_F000, 32'h8000_0000},
   parameter int                  TIMEOUT_CYC = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   apb_interconnect_if.slave bus
);

   localparam int IDX_W = (N_TGT > 1) ? $clog2(N_TGT) : 1;

   typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RESP, ERR} state_t;

   state_t                state, state_nxt;
   logic                  setup_req;
   logic                  hit;
   logic [IDX_W-1:0]      hit_idx;
   logic [IDX_W-1:0]      tgt_idx;
   logic                  sel_ready;
   logic                  timed_out;
   logic [TGT_ADDR_W-1:0] paddr_q;
   logic                  pwrite_q;
   logic [31:0]           pwdata_q;
   logic [3:0]            pwstrb_q;
   logic [31:0]           rdata_q;
   logic                  slverr_q;

   assign setup_req = bus.i_psel & ~bus.i_penable;
   assign sel_ready = bus.t_pready[tgt_idx];

   // Scan from the top index down so the lowest matching region wins.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int k = N_TGT - 1; k >= 0; k--) begin
         if ((bus.i_paddr & ADDR_MASK[k*32 +: 32]) == BASE_ADDR[k*32 +: 32]) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(k);
         end
      end
   end

`ifdef APB_INTERCONNECT_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] acc_cnt;

   // Held at zero outside ACCESS, so it is clear on every entry to ACCESS and
   // counts the ACCESS cycles already completed.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_cnt <= '0;
      end else if (state != ACCESS) begin
         acc_cnt <= '0;
      end else begin
         acc_cnt <= acc_cnt + 1'b1;
      end
   end

   // True in the last ACCESS cycle the target is allowed.
   assign timed_out = (acc_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
   assign timed_out = 1'b0;

   // TIMEOUT_CYC only shapes the timeout build; the empty block keeps it
   // elaborated here.
   if (TIMEOUT_CYC < 1) begin : g_timeout_cyc_unused
   end
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (setup_req) state_nxt = hit ? SETUP : ERR;
         SETUP:   state_nxt = ACCESS;
         // A ready target wins over a timeout in the same cycle.
         ACCESS:  if (sel_ready) state_nxt = RESP;
                  else if (timed_out) state_nxt = ERR;
         RESP:    state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.i_pready  = 1'b0;
      bus.i_pslverr = 1'b0;
      bus.i_prdata  = '0;
      bus.t_psel    = '0;
      bus.t_penable = 1'b0;
      case (state)
         SETUP: begin
            bus.t_psel[tgt_idx] = 1'b1;
         end
         ACCESS: begin
            bus.t_psel[tgt_idx] = 1'b1;
            bus.t_penable       = 1'b1;
         end
         RESP: begin
            bus.i_pready  = 1'b1;
            bus.i_pslverr = slverr_q;
            bus.i_prdata  = rdata_q;
         end
         ERR: begin
            bus.i_pready  = 1'b1;
            bus.i_pslverr = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.t_paddr  = paddr_q;
   assign bus.t_pwrite = pwrite_q;
   assign bus.t_pwdata = pwdata_q;
   assign bus.t_pwstrb = pwstrb_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         tgt_idx  <= '0;
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
         pwstrb_q <= '0;
         rdata_q  <= '0;
         slverr_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && setup_req) begin
            tgt_idx  <= hit_idx;
            paddr_q  <= bus.i_paddr[TGT_ADDR_W-1:0];
            pwrite_q <= bus.i_pwrite;
            pwdata_q <= bus.i_pwdata;
            pwstrb_q <= bus.i_pwstrb;
         end
         if (state == ACCESS && sel_ready) begin
            rdata_q  <= bus.t_prdata[{tgt_idx, 5'd0} +: 32];
            slverr_q <= bus.t_pslverr[tgt_idx];
         end
      end
   end

endmodule

// File: tb/tb_apb_interconnect.sv
// ----------------------------------------------------------------------------
// tb_apb_interconnect
// Directed bench for apb_interconnect (default regions: target 0 at
// 0x8000_0000/0x8000_0000, target 1 at 0x1000_0000/0xFFFF_F000).
// A transaction-level model predicts every output cycle from the accepted
// request, its decoded target and the number of wait states the target model
// inserts; each transfer also carries hand-computed latency/response values.
// With APB_INTERCONNECT_TIMEOUT_EN defined, a timeout case (TIMEOUT_CYC=4)
// is added.
// ----------------------------------------------------------------------------
module tb_apb_interconnect;

   localparam int N_TGT      = 2;
   localparam int TGT_ADDR_W = 31;
   localparam int TO_CYC     = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   apb_interconnect_if #(.N_TGT(N_TGT), .TGT_ADDR_W(TGT_ADDR_W)) bus ();

   apb_interconnect #(
      .N_TGT      (N_TGT),
      .TGT_ADDR_W (TGT_ADDR_W),
      .TIMEOUT_CYC(TO_CYC)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Current transfer as seen by the target model and the reference model.
   int          cur_w  = 0;
   logic [31:0] cur_rd = '0;
   logic        cur_se = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [127:0] pack(input logic rdy, input logic err,
                                         input logic [31:0] rd, input logic [1:0] sel,
                                         input logic en, input logic wr,
                                         input logic [30:0] pa, input logic [31:0] wd,
                                         input logic [3:0] st);
      return {23'd0, rdy, err, rd, sel, en, wr, pa, wd, st};
   endfunction

   function automatic logic [127:0] obs();
      return pack(bus.i_pready, bus.i_pslverr, bus.i_prdata, bus.t_psel, bus.t_penable,
                  bus.t_pwrite, bus.t_paddr, bus.t_pwdata, bus.t_pwstrb);
   endfunction

   // Region decode, lowest target first; -1 means no target.
   function automatic int decode(input logic [31:0] a);
      if ((a & 32'h8000_0000) == 32'h8000_0000) return 0;
      if ((a & 32'hFFFF_F000) == 32'h1000_0000) return 1;
      return -1;
   endfunction

   // ---------------- reference model ----------------
   // cyc is the index of the cycle that begins at the latest rising edge.
   // A transfer accepted at the edge ending cycle ms is busy in cycles
   // ms+1 .. ms+mlast; mkind: 0 hit, 1 miss, 2 timeout.
   int          cyc    = 0;
   bit          mvalid = 1'b0;
   bit          mact   = 1'b0;
   int          ms     = 0;
   int          mlast  = 0;
   int          mkind  = 0;
   logic [1:0]  msel   = '0;
   logic        m_wr   = 1'b0;
   logic [30:0] m_pa   = '0;
   logic [31:0] m_wd   = '0;
   logic [3:0]  m_st   = '0;
   logic [31:0] m_rd   = '0;
   logic        m_se   = 1'b0;

   always @(posedge clk) begin : model
      int k;
      cyc++;
      if (!rst_n) begin
         mvalid = 1'b1;
         mact   = 1'b0;
         m_wr   = 1'b0;
         m_pa   = '0;
         m_wd   = '0;
         m_st   = '0;
      end else if (mvalid && (!mact || (cyc - 1 - ms) > mlast) &&
                   bus.i_psel === 1'b1 && bus.i_penable === 1'b0) begin
         k    = decode(bus.i_paddr);
         mact = 1'b1;
         ms   = cyc - 1;
         m_wr = bus.i_pwrite;
         m_pa = bus.i_paddr[30:0];
         m_wd = bus.i_pwdata;
         m_st = bus.i_pwstrb;
         m_rd = cur_rd;
         m_se = cur_se;
         if (k < 0) begin
            mkind = 1;
            mlast = 1;
            msel  = '0;
         end else begin
            mkind = 0;
            msel  = 2'(1 << k);
            mlast = 3 + cur_w;
`ifdef APB_INTERCONNECT_TIMEOUT_EN
            if (cur_w >= TO_CYC) begin
               mkind = 2;
               mlast = 2 + TO_CYC;
            end
`endif
         end
      end
   end

   always @(negedge clk) begin : compare
      int          rel;
      logic        rdy, err, en;
      logic [31:0] rd;
      logic [1:0]  sel;
      if (mvalid) begin
         rdy = 1'b0; err = 1'b0; en = 1'b0; rd = '0; sel = '0;
         rel = cyc - ms;
         if (mact && rel >= 1 && rel <= mlast) begin
            if (mkind == 1) begin
               rdy = 1'b1;
               err = 1'b1;
            end else if (rel == mlast) begin
               rdy = 1'b1;
               if (mkind == 2) begin
                  err = 1'b1;
               end else begin
                  err = m_se;
                  rd  = m_rd;
               end
            end else begin
               sel = msel;
               en  = (rel >= 2);
            end
         end
         chk("cycle", obs(), pack(rdy, err, rd, sel, en, m_wr, m_pa, m_wd, m_st));
      end
   end

   // ---------------- target model ----------------
   // The selected target raises t_pready in its (cur_w+1)-th ACCESS cycle.
   // Unselected targets show ready/error and distinct read data to expose
   // any wrong response selection.
   int acc = 0;

   always @(posedge clk) begin : targets
      logic rdy_now;
      #1;
      if (bus.t_penable === 1'b1) begin
         rdy_now = (acc == cur_w);
         acc++;
      end else begin
         rdy_now = 1'b0;
         acc     = 0;
      end
      bus.t_pready  = rdy_now ? '1 : ~bus.t_psel;
      bus.t_pslverr = ~bus.t_psel | (cur_se ? bus.t_psel : 2'b00);
      for (int k = 0; k < N_TGT; k++)
         bus.t_prdata[k*32 +: 32] = bus.t_psel[k] ? cur_rd : (32'hBAD0_0000 | 32'(k));
   end

   // ---------------- initiator ----------------
   // Starts in the drive slot (#1 after an edge) and returns in the IDLE
   // cycle following the response.
   task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       input logic [3:0] st, input int w, input logic [31:0] rd,
                       input logic se, input logic drop,
                       input logic [1:0] exp_sel, input logic [30:0] exp_pa,
                       input int exp_lat, input logic [31:0] exp_rd, input logic exp_err);
      int lat;
      cur_w  = w;
      cur_rd = rd;
      cur_se = se;
      bus.i_psel    = 1'b1;
      bus.i_penable = 1'b0;
      bus.i_paddr   = addr;
      bus.i_pwrite  = wr;
      bus.i_pwdata  = wd;
      bus.i_pwstrb  = st;
      @(posedge clk); #1;
      lat = 1;
      chk("setup_psel", {126'd0, bus.t_psel}, {126'd0, exp_sel});
      chk("setup_paddr", {97'd0, bus.t_paddr}, {97'd0, exp_pa});
      if (drop) bus.i_psel = 1'b0;
      else      bus.i_penable = 1'b1;
      while (bus.i_pready !== 1'b1 && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", 128'(lat), 128'(exp_lat));
      chk("response", {95'd0, bus.i_pslverr, bus.i_prdata}, {95'd0, exp_err, exp_rd});
      bus.i_psel    = 1'b0;
      bus.i_penable = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      bus.i_psel    = 1'b0;
      bus.i_penable = 1'b0;
      bus.i_paddr   = '0;
      bus.i_pwrite  = 1'b0;
      bus.i_pwdata  = '0;
      bus.i_pwstrb  = '0;
      bus.t_pready  = '1;
      bus.t_pslverr = '0;
      bus.t_prdata  = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", obs(), 128'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // write to target 0, zero wait
      xfer(32'h8000_0010, 1'b1, 32'hCAFE_F00D, 4'hF, 0, 32'h0, 1'b0, 1'b0,
           2'b01, 31'h0000_0010, 3, 32'h0, 1'b0);
      // read from target 1, three wait states (issued back to back)
      xfer(32'h1000_0004, 1'b0, 32'h0, 4'h0, 3, 32'h0000_0041, 1'b0, 1'b0,
           2'b10, 31'h1000_0004, 6, 32'h0000_0041, 1'b0);
      // unmapped address
      xfer(32'h2000_0000, 1'b0, 32'h0, 4'h0, 0, 32'h0000_0077, 1'b0, 1'b0,
           2'b00, 31'h2000_0000, 1, 32'h0, 1'b1);
      // target 0 reports an error on a write
      xfer(32'h8000_0020, 1'b1, 32'h1234_5678, 4'h3, 0, 32'h0, 1'b1, 1'b0,
           2'b01, 31'h0000_0020, 3, 32'h0, 1'b1);
      // last word of the target 1 region, one wait state, partial strobes
      xfer(32'h1000_0FFC, 1'b1, 32'hA5A5_5A5A, 4'h5, 1, 32'h0, 1'b0, 1'b0,
           2'b10, 31'h1000_0FFC, 4, 32'h0, 1'b0);
      // first word past the target 1 region
      xfer(32'h1000_1000, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0, 1'b0,
           2'b00, 31'h1000_1000, 1, 32'h0, 1'b1);
      // top of the address space: target 0, bit 31 not forwarded
      xfer(32'hFFFF_FFFC, 1'b0, 32'h0, 4'h0, 2, 32'h89AB_CDEF, 1'b0, 1'b0,
           2'b01, 31'h7FFF_FFFC, 5, 32'h89AB_CDEF, 1'b0);
      // initiator drops psel right after setup; transfer still completes
      xfer(32'h1000_0008, 1'b0, 32'h0, 4'h0, 2, 32'h0000_0055, 1'b0, 1'b1,
           2'b10, 31'h1000_0008, 5, 32'h0000_0055, 1'b0);
`ifdef APB_INTERCONNECT_TIMEOUT_EN
      // target 1 never ready: four ACCESS cycles, then error response
      xfer(32'h1000_0010, 1'b0, 32'h0, 4'h0, 1000, 32'h0000_DEAD, 1'b0, 1'b0,
           2'b10, 31'h1000_0010, 6, 32'h0, 1'b1);
`endif

      // reset during ACCESS aborts the transfer
      cur_w  = 50;
      cur_rd = 32'h0BAD_BEEF;
      cur_se = 1'b0;
      bus.i_psel    = 1'b1;
      bus.i_penable = 1'b0;
      bus.i_paddr   = 32'h8000_0100;
      bus.i_pwrite  = 1'b0;
      bus.i_pwdata  = 32'h1111_2222;
      bus.i_pwstrb  = 4'hC;
      @(posedge clk); #1;
      bus.i_penable = 1'b1;
      @(posedge clk); #1;
      chk("abort_in_access", {127'd0, bus.t_penable}, 128'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("abort_outputs", obs(), 128'd0);
      rst_n         = 1'b1;
      bus.i_psel    = 1'b0;
      bus.i_penable = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         chk("abort_no_ready", {127'd0, bus.i_pready}, 128'd0);
      end

      // normal read after the abort
      xfer(32'h8000_0200, 1'b0, 32'h0, 4'h0, 1, 32'h1357_9BDF, 1'b0, 1'b0,
           2'b01, 31'h0000_0200, 4, 32'h1357_9BDF, 1'b0);

      repeat (2) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
